// File: rtl/gsm_pkg.sv
// gsm_pkg: shared ASCII constants, token strings and parser state for the GSM modem link
package gsm_pkg;
  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] CHAR_GT     = 8'h3E;
  localparam logic [7:0] CHAR_CTRL_Z = 8'h1A;
  localparam logic [15:0] TOK_OK     = "OK";
  localparam logic [39:0] TOK_ERROR  = "ERROR";
  localparam logic [15:0] TOK_PROMPT = "> ";
  typedef enum logic [2:0] {LINE_START, M_OK, M_ERR, M_PROMPT, SKIP} parse_state_e;
  // Byte expected at match index i (1..3) of the line "OK\r\n"
  function automatic logic [7:0] ok_byte(input logic [2:0] i);
    return i == 3'd1 ? TOK_OK[7:0] : i == 3'd2 ? CHAR_CR : CHAR_LF;
  endfunction
  // Byte expected at match index i (1..6) of the line "ERROR\r\n"
  function automatic logic [7:0] err_byte(input logic [2:0] i);
    int k;
    k = i < 3'd5 ? 4 - int'(i) : 0;
    return i < 3'd5 ? TOK_ERROR[8*k +: 8] : i == 3'd5 ? CHAR_CR : CHAR_LF;
  endfunction
endpackage

// File: rtl/gsm_timeout_timer.sv
// gsm_timeout_timer: response wait flag and saturating timeout counter started by arm
module gsm_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 16000000,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic token,
  output logic waiting,
  output logic timeout
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic waiting_q, waiting_d, timeout_q, timeout_d, expire;
  // A token or a fresh arm on the expiry cycle suppresses the timeout
  always_comb begin
    expire    = waiting_q && cnt_q == LAST && !token && !arm;
    cnt_d     = arm ? '0 : (waiting_q && cnt_q != LAST) ? cnt_q + CNT_W'(1) : cnt_q;
    waiting_d = arm || (waiting_q && !token && !expire);
    timeout_d = expire;
  end
  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      waiting_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      waiting_q <= waiting_d;
      timeout_q <= timeout_d;
    end
  end
  assign waiting = waiting_q;
  assign timeout = timeout_q;
endmodule

// File: rtl/gsm_response_parser.sv
// gsm_response_parser: detects OK / ERROR / "> " modem responses; timeout enabled by GSM_RESP_TIMEOUT_EN
module gsm_response_parser #(
  parameter int TIMEOUT_CYCLES = 16000000,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       arm,
  output logic       ok_seen,
  output logic       error_seen,
  output logic       prompt_seen,
  output logic       waiting,
  output logic       timeout
);
  import gsm_pkg::*;
  parse_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic ok_q, ok_d, err_q, err_d, prm_q, prm_d, hit, last;
  // Byte-serial line matcher; holds whenever rx_valid is low
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    prm_d   = 1'b0;
    hit     = 1'b0;
    last    = 1'b0;
    if (rx_valid) begin
      case (state_q)
        LINE_START: begin
          state_d = (rx_data == CHAR_CR || rx_data == CHAR_LF) ? LINE_START :
                    rx_data == TOK_OK[15:8]    ? M_OK :
                    rx_data == TOK_ERROR[39:32] ? M_ERR :
                    rx_data == CHAR_GT         ? M_PROMPT : SKIP;
          idx_d = 3'd1;
        end
        M_OK, M_ERR: begin
          hit  = rx_data == (state_q == M_OK ? ok_byte(idx_q) : err_byte(idx_q));
          last = idx_q == (state_q == M_OK ? 3'd3 : 3'd6);
          if (!hit) state_d = rx_data == CHAR_LF ? LINE_START : SKIP;
          else if (last) begin
            state_d = LINE_START;
            ok_d    = state_q == M_OK;
            err_d   = state_q == M_ERR;
          end else idx_d = idx_q + 3'd1;
        end
        M_PROMPT: begin
          prm_d   = rx_data == CHAR_SPACE;
          state_d = (rx_data == CHAR_LF) ? LINE_START : SKIP;
        end
        SKIP: state_d = rx_data == CHAR_LF ? LINE_START : SKIP;
        default: state_d = LINE_START;
      endcase
      if (state_d == LINE_START) idx_d = 3'd0;
    end
  end
  // Parser state and registered token pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LINE_START;
      idx_q   <= 3'd0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      prm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      prm_q   <= prm_d;
    end
  end
  assign ok_seen     = ok_q;
  assign error_seen  = err_q;
  assign prompt_seen = prm_q;
`ifdef GSM_RESP_TIMEOUT_EN
  gsm_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .arm(arm), .token(ok_d | err_d | prm_d),
    .waiting(waiting), .timeout(timeout)
  );
`else
  logic waiting_q, waiting_d;
  // Wait flag without time limit: arm sets, any token clears, arm wins
  always_comb waiting_d = arm || (waiting_q && !(ok_d || err_d || prm_d));
  // Wait flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) waiting_q <= 1'b0;
    else waiting_q <= waiting_d;
  end
  assign waiting = waiting_q;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_gsm_response_parser.sv
// tb_gsm_response_parser: scoreboard bench for the GSM response parser
module tb_gsm_response_parser;
  localparam logic [3:0] K_OK = 4'b0001, K_ERR = 4'b0010, K_PRM = 4'b0100, K_TO = 4'b1000;
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A;
  typedef struct {logic [3:0] kind; int cyc;} exp_t;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, arm = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic ok_seen, error_seen, prompt_seen, waiting, timeout;
  int cyc = 0, checks = 0, failures = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [3:0] got;
  gsm_response_parser #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .arm(arm),
    .ok_seen(ok_seen), .error_seen(error_seen), .prompt_seen(prompt_seen),
    .waiting(waiting), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] g, input logic [31:0] w);
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, g, w, cyc);
    end
  endtask
  task automatic expect_at(input logic [3:0] k, input int c);
    exp_q.push_back('{k, c});
  endtask
  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask
  // Monitor: every output pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && (ok_seen || error_seen || prompt_seen || timeout)) begin
      got = {timeout, prompt_seen, error_seen, ok_seen};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got=%b at cycle %0d", got, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== got || e.cyc != cyc) begin
          failures++;
          $display("FAIL pulse got=%b@%0d want=%b@%0d", got, cyc, e.kind, e.cyc);
        end
      end
      if (timeout) begin
        checks++;
        if (waiting !== 1'b0) begin
          failures++;
          $display("FAIL waiting_at_timeout got=%b want=0", waiting);
        end
      end
    end
  end
  initial begin
    logic [7:0] t2[9];
    t2 = '{CR, LF, "E", "R", "R", "O", "R", CR, LF};
    idle(2);
    check("reset_outputs", {27'd0, ok_seen, error_seen, prompt_seen, waiting, timeout}, 0);
    rst = 1'b0;
    idle(1);
    put("O"); put("K"); put(CR);
    expect_at(K_OK, cyc + 1);
    put(LF);
    idle(3);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) expect_at(K_ERR, cyc + 1);
      put(t2[i]);
      idle(3);
    end
    pulse_arm();
    check("waiting_after_arm", waiting, 1);
    put(">");
    expect_at(K_PRM, cyc + 1);
    put(" ");
    check("prompt_pulse", prompt_seen, 1);
    check("waiting_falls_on_prompt", waiting, 0);
    put(LF);
    put_str("OKAY"); put(CR); put(LF);
    put_str("OK"); put(CR);
    expect_at(K_OK, cyc + 1);
    put(LF);
    put_str("+CMTI: \"SM\",1"); put(CR); put(LF);
    idle(3);
`ifdef GSM_RESP_TIMEOUT_EN
    expect_at(K_TO, cyc + 17);
    pulse_arm();
    idle(25);
    check("waiting_after_timeout", waiting, 0);
    pulse_arm();
    idle(9);
    expect_at(K_TO, cyc + 17);
    pulse_arm();
    idle(10);
    check("waiting_before_rearm_timeout", waiting, 1);
    idle(20);
    check("waiting_after_rearm_timeout", waiting, 0);
`else
    pulse_arm();
    idle(40);
    check("waiting_held_no_timer", waiting, 1);
    check("timeout_tied_low", timeout, 0);
    put("O"); put("K"); put(CR);
    expect_at(K_OK, cyc + 1);
    put(LF);
    check("waiting_falls_on_ok", waiting, 0);
`endif
    pulse_arm();
    put("E"); put("R");
    rst = 1'b1;
    #1;
    check("outputs_in_reset", {27'd0, ok_seen, error_seen, prompt_seen, waiting, timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    put_str("ROR"); put(CR); put(LF);
    put_str("OK"); put(CR);
    expect_at(K_OK, cyc + 1);
    put(LF);
    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gsm_response_parser.md
# gsm_response_parser

- Receive-side companion to the GSM AT-command transmitter.
- Consumes the modem's UART byte stream and recognises the final result lines `OK` and `ERROR`, plus the SMS text prompt `> `.
- Emits a single-cycle pulse for each recognised token and runs an optional response timeout.
- Sits between the UART receiver and the alert sequencer, so the sequencer advances on real modem responses instead of fixed wait counts.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16000000: clock cycles from `arm` to `timeout` pulse; legal range 2 and up.
- CNT_W, default $clog2(TIMEOUT_CYCLES+1): timeout counter width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte; back-to-back strobes allowed.
- arm  in  1  pulse: a command was just sent; start waiting for a response.
- ok_seen  out  1  one-cycle pulse: line `OK\r\n` completed.
- error_seen  out  1  one-cycle pulse: line `ERROR\r\n` completed.
- prompt_seen  out  1  one-cycle pulse: `> ` seen at line start.
- waiting  out  1  high from arm until a response or timeout.
- timeout  out  1  one-cycle pulse: TIMEOUT_CYCLES elapsed while waiting.

## Operation
Matching is byte-serial and line-oriented. Parser FSM states:
- LINE_START: CR (0x0D) and LF (0x0A) stay here.
  - 'O' goes to M_OK, with index 1.
  - 'E' goes to M_ERR, with index 1.
  - '>' goes to M_PROMPT.
  - Any other byte goes to SKIP.
- M_OK: expects 'K', then CR, then LF in order.
  - LF completes the match: pulse ok_seen, go to LINE_START.
- M_ERR: expects 'R','R','O','R', then CR, then LF in order.
  - LF completes the match: pulse error_seen, go to LINE_START.
- M_PROMPT: space (0x20) completes the match.
  - Pulse prompt_seen and go to SKIP; the prompt line is never LF-terminated, and SKIP exits on the next LF.
- Mismatch in any M_* state:
  - LF goes to LINE_START.
  - Any other byte goes to SKIP.
- SKIP: discard bytes until LF, then go to LINE_START.
- Match index: 3 bits, reset to 0 on entry to LINE_START.
- Matching is case-sensitive. Bytes with rx_valid=0 are ignored, and the FSM holds.

Wait tracking:
- `arm` sets waiting=1 and clears the counter.
- Any of ok_seen, error_seen or prompt_seen clears waiting.
- When the counter reaches TIMEOUT_CYCLES-1 while waiting: pulse timeout, clear waiting.
- Pulses are generated whether or not waiting=1.

## Timing
- All outputs are registered. The token pulse asserts in the cycle after the clock edge that samples the final byte with rx_valid=1.
- Reset values: FSM=LINE_START, index=0, counter=0, all outputs 0.
- Reset mid-line discards the partial match; the next byte is treated as line start.
- Simultaneous arm and completed match in the same cycle:
  - The match pulse is emitted.
  - arm wins: waiting=1 and the counter is cleared.
- arm while already waiting restarts the count.
- timeout asserts exactly TIMEOUT_CYCLES cycles after the arm-sampling edge. waiting falls in the same cycle.
- A match on the cycle the counter would expire takes priority: ok/error/prompt pulses and timeout does not.
- The counter saturates; it does not wrap and is idle when waiting=0.

## Configuration
- Macro GSM_RESP_TIMEOUT_EN.
- Defined: counter, `waiting` and `timeout` behave as above.
- Undefined: counter logic is absent. `timeout` is tied to 0. `waiting` still sets on arm and clears on a token, and never clears by time.

## Structure
- Shared package gsm_pkg holds:
  - ASCII constants: CHAR_CR, CHAR_LF, CHAR_SPACE, CHAR_GT, CHAR_CTRL_Z.
  - The parser state enum.
  - The token strings as byte constants, shared with the transmitter.
- One sub-module, gsm_timeout_timer, holds the counter and the `waiting`/`timeout` logic. It is instantiated only under GSM_RESP_TIMEOUT_EN.

## Test plan
- Bytes `O`,`K`,CR,LF back-to-back → exactly one ok_seen pulse, one cycle after the LF strobe; error_seen and prompt_seen stay 0.
- CR,LF,`ERROR`,CR,LF with 3 idle cycles between bytes → one error_seen pulse after the final LF.
- arm, then `>`,0x20 → prompt_seen pulse after the space; waiting falls in the same cycle.
- `OKAY`,CR,LF,`OK`,CR,LF → only one ok_seen, after the second LF. `+CMTI: "SM",1`,CR,LF → no pulses.
- TIMEOUT_CYCLES=16, arm, no bytes → timeout pulse exactly 16 cycles after arm; a second arm at cycle 10 delays it to 16 cycles after that arm.
- `E`,`R`, assert rst, then `ROR`,CR,LF → no error_seen; all outputs 0 during reset.
